// File: rtl/correlation_sequencer_if.sv
// correlation_sequencer_if
// Bundles the handshake and data signals between the DOA sequencer and its
// surroundings (correlator, vector mux, result consumer).
//   start       arm one measurement
//   xCorrValid  one-cycle pulse per correlator sample update
//   xCorrIn     correlation vector of the pair selected by xCorrSel
//   corrEnable  gate for the correlator sample-valid
//   xCorrSel    pair index currently scanned
//   busy        measurement in progress
//   validOut    one-cycle pulse, lag outputs updated
//   lagOut0..5  signed peak lag per microphone pair
// master = driver/consumer side, slave = the sequencer itself.
interface correlation_sequencer_if #(
  parameter int MAX_SAMPLES_DELAY = 11,
  parameter int NUM_BITS_XCORR    = 32,
  parameter int LAG_BITS          = $clog2(MAX_SAMPLES_DELAY + 1) + 1
);
  logic                                                  start;
  logic                                                  xCorrValid;
  logic signed [2*MAX_SAMPLES_DELAY:0][NUM_BITS_XCORR-1:0] xCorrIn;
  logic                                                  corrEnable;
  logic [2:0]                                            xCorrSel;
  logic                                                  busy;
  logic                                                  validOut;
  logic signed [LAG_BITS-1:0]                            lagOut0;
  logic signed [LAG_BITS-1:0]                            lagOut1;
  logic signed [LAG_BITS-1:0]                            lagOut2;
  logic signed [LAG_BITS-1:0]                            lagOut3;
  logic signed [LAG_BITS-1:0]                            lagOut4;
  logic signed [LAG_BITS-1:0]                            lagOut5;

  modport master (
    output start, xCorrValid, xCorrIn,
    input  corrEnable, xCorrSel, busy, validOut,
    input  lagOut0, lagOut1, lagOut2, lagOut3, lagOut4, lagOut5
  );

  modport slave (
    input  start, xCorrValid, xCorrIn,
    output corrEnable, xCorrSel, busy, validOut,
    output lagOut0, lagOut1, lagOut2, lagOut3, lagOut4, lagOut5
  );
endinterface

// File: rtl/correlation_sequencer.sv
// correlation_sequencer
// Sequences one direction-of-arrival measurement: lets the correlator absorb
// NUM_SAMPLES fresh samples, then freezes it and scans the six
// cross-correlation vectors one lag per cycle, reporting the lag of each
// vector's maximum as a signed sample delay.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  correlation_sequencer_if.slave (start, xCorrValid, xCorrIn in;
//        corrEnable, xCorrSel, busy, validOut, lagOut0..5 out)
module correlation_sequencer #(
  parameter int NUM_SAMPLES       = 1024,
  parameter int MAX_SAMPLES_DELAY = 11,
  parameter int NUM_BITS_XCORR    = 32,
  parameter int NUM_XCORRS        = 6,
  parameter int LAG_BITS          = $clog2(MAX_SAMPLES_DELAY + 1) + 1
) (
  input logic                     clk,
  input logic                     rst,
  correlation_sequencer_if.slave  bus
);

  localparam int NUM_LAGS = 2 * MAX_SAMPLES_DELAY + 1;
  localparam int K_BITS   = $clog2(NUM_LAGS);
  localparam int CNT_BITS = $clog2(NUM_SAMPLES + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] SCAN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]                       state_reg, state_next;
  logic [CNT_BITS-1:0]              cnt_reg;
  logic [K_BITS-1:0]                k_reg;
  logic [2:0]                       p_reg;
  logic signed [NUM_BITS_XCORR-1:0] best_reg;
  logic [K_BITS-1:0]                best_idx_reg;
  logic                             corr_enable_reg;

  logic                             cnt_last;
  logic                             k_last;
  logic                             p_last;
  logic signed [NUM_BITS_XCORR-1:0] cur_val;
  logic signed [NUM_BITS_XCORR-1:0] cand_best;
  logic [K_BITS-1:0]                cand_idx;
  logic signed [LAG_BITS-1:0]       lag_calc;
  logic signed [LAG_BITS-1:0]       lag_reg [NUM_XCORRS];

  assign cnt_last = (cnt_reg == CNT_BITS'(NUM_SAMPLES - 1));
  assign k_last   = (k_reg == K_BITS'(NUM_LAGS - 1));
  assign p_last   = (p_reg == 3'(NUM_XCORRS - 1));

  // Running argmax including the current lag, so the final comparison of a
  // pair is already folded in when its lag is written out.
  always_comb begin
    cur_val   = $signed(bus.xCorrIn[k_reg]);
    cand_best = best_reg;
    cand_idx  = best_idx_reg;
    if (k_reg == '0) begin
      cand_best = cur_val;
      cand_idx  = '0;
    end else if (cur_val > best_reg) begin
      // strict compare: ties keep the lowest index
      cand_best = cur_val;
      cand_idx  = k_reg;
    end
    // index 0..2M maps to lag -M..+M; modular subtraction is exact here
    lag_calc = LAG_BITS'(cand_idx) - LAG_BITS'(MAX_SAMPLES_DELAY);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = FILL;
      FILL:    if (bus.xCorrValid && cnt_last) state_next = SCAN;
      SCAN:    if (k_last && p_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      k_reg           <= '0;
      p_reg           <= '0;
      best_reg        <= '0;
      best_idx_reg    <= '0;
      corr_enable_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      // registered gate: follows the state being entered
      corr_enable_reg <= (state_next == FILL);
      case (state_reg)
        IDLE: begin
          if (bus.start) cnt_reg <= '0;
        end
        FILL: begin
          if (bus.xCorrValid) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_last) begin
              k_reg <= '0;
              p_reg <= '0;
            end
          end
        end
        SCAN: begin
          best_reg     <= cand_best;
          best_idx_reg <= cand_idx;
          if (k_last) begin
            k_reg <= '0;
            // park the selector on pair 0 once the last pair is finished
            p_reg <= p_last ? 3'd0 : p_reg + 3'd1;
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // One result register per pair, written on the last lag of that pair.
  generate
    for (genvar gi = 0; gi < NUM_XCORRS; gi++) begin : g_lag
      always_ff @(posedge clk) begin
        if (rst) begin
          lag_reg[gi] <= '0;
        end else if (state_reg == SCAN && k_last && p_reg == 3'(gi)) begin
          lag_reg[gi] <= lag_calc;
        end
      end
    end
  endgenerate

  assign bus.corrEnable = corr_enable_reg;
  assign bus.xCorrSel   = p_reg;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.validOut   = (state_reg == DONE);
  assign bus.lagOut0    = lag_reg[0];
  assign bus.lagOut1    = lag_reg[1];
  assign bus.lagOut2    = lag_reg[2];
  assign bus.lagOut3    = lag_reg[3];
  assign bus.lagOut4    = lag_reg[4];
  assign bus.lagOut5    = lag_reg[5];

endmodule

// File: tb/tb_correlation_sequencer.sv
// tb_correlation_sequencer
// Scoreboard bench for correlation_sequencer built with NUM_SAMPLES=8.
// Expected lag sets are queued when the test vectors are loaded and popped
// when validOut pulses.
module tb_correlation_sequencer;
  localparam int NS = 8;
  localparam int M  = 11;
  localparam int NB = 32;
  localparam int NX = 6;
  localparam int LB = 5;
  localparam int NK = 2 * M + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  correlation_sequencer_if #(.MAX_SAMPLES_DELAY(M), .NUM_BITS_XCORR(NB), .LAG_BITS(LB)) bus ();

  correlation_sequencer #(
    .NUM_SAMPLES(NS), .MAX_SAMPLES_DELAY(M), .NUM_BITS_XCORR(NB),
    .NUM_XCORRS(NX), .LAG_BITS(LB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // external vector mux model
  logic signed [NB-1:0] vecs [NX][NK];
  logic [NK-1:0][NB-1:0] xin;
  always_comb begin
    int sel;
    sel = int'(bus.xCorrSel);
    xin = '0;
    if (sel < NX) begin
      for (int k = 0; k < NK; k++) xin[k] = vecs[sel][k];
    end
  end
  assign bus.xCorrIn = xin;

  logic signed [LB-1:0] lag_obs [NX];
  assign lag_obs[0] = bus.lagOut0;
  assign lag_obs[1] = bus.lagOut1;
  assign lag_obs[2] = bus.lagOut2;
  assign lag_obs[3] = bus.lagOut3;
  assign lag_obs[4] = bus.lagOut4;
  assign lag_obs[5] = bus.lagOut5;

  int checks = 0;
  int failures = 0;
  logic [LB*NX-1:0] exp_q [$];

  task automatic check_value(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_valid();
    bus.xCorrValid = 1'b1;
    tick();
    bus.xCorrValid = 1'b0;
    repeat (3) tick();
  endtask

  // vector with random background 0..1000 and one clear peak
  task automatic fill_peak(input int p, input int idx);
    for (int k = 0; k < NK; k++) vecs[p][k] = NB'($urandom_range(0, 1000));
    vecs[p][idx] = 32'sd100000;
  endtask

  // expected lag for a winning index is simply index - M
  task automatic push_expected(input int i0, input int i1, input int i2,
                               input int i3, input int i4, input int i5);
    logic [LB*NX-1:0] w;
    int idx [NX];
    idx = '{i0, i1, i2, i3, i4, i5};
    for (int i = 0; i < NX; i++) w[LB*i +: LB] = LB'(idx[i] - M);
    exp_q.push_back(w);
  endtask

  task automatic check_lags_zero(input string tag);
    for (int i = 0; i < NX; i++)
      check_value($sformatf("%s_lag%0d", tag, i), lag_obs[i], 0);
  endtask

  task automatic run_measure(input bit poke_scan, input bit hold_start);
    int cyc;
    logic [LB*NX-1:0] w;
    logic signed [LB-1:0] e;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_value("fill_corrEnable", bus.corrEnable, 1);
    for (int i = 0; i < NS - 1; i++) pulse_valid();
    check_value("fill7_corrEnable", bus.corrEnable, 1);
    check_value("fill7_busy", bus.busy, 1);
    bus.xCorrValid = 1'b1;
    tick();
    bus.xCorrValid = 1'b0;
    check_value("scan_corrEnable", bus.corrEnable, 0);
    cyc = 0;
    while (!bus.validOut && cyc < 400) begin
      if (poke_scan) begin
        bus.start      = (cyc == 20);
        bus.xCorrValid = (cyc == 20 || cyc == 60 || cyc == 100);
      end
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    bus.xCorrValid = 1'b0;
    check_value("scan_len", cyc, NX * NK);
    check_value("done_validOut", bus.validOut, 1);
    check_value("sb_nonempty", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      for (int i = 0; i < NX; i++) begin
        e = w[LB*i +: LB];
        check_value($sformatf("lag%0d", i), lag_obs[i], e);
      end
    end
    if (hold_start) bus.start = 1'b1;
    tick();
    check_value("post_validOut", bus.validOut, 0);
    check_value("post_busy", bus.busy, 0);
    if (hold_start) begin
      tick();
      check_value("restart_busy", bus.busy, 1);
      check_value("restart_corrEnable", bus.corrEnable, 1);
      bus.start = 1'b0;
    end
  endtask

  initial begin
    int cyc;
    int vcount;
    int en_seen;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.xCorrValid = 1'b0;
    for (int p = 0; p < NX; p++)
      for (int k = 0; k < NK; k++) vecs[p][k] = '0;
    tick();
    tick();
    rst = 1'b0;
    check_value("rst_corrEnable", bus.corrEnable, 0);
    check_value("rst_busy", bus.busy, 0);
    check_value("rst_validOut", bus.validOut, 0);
    check_value("rst_xCorrSel", bus.xCorrSel, 0);
    check_lags_zero("rst");

    // xCorrValid without start must do nothing
    vcount = 0;
    en_seen = 0;
    for (int i = 0; i < 10; i++) begin
      bus.xCorrValid = 1'b1;
      for (int j = 0; j < 4; j++) begin
        tick();
        bus.xCorrValid = 1'b0;
        vcount += int'(bus.validOut);
        en_seen += int'(bus.corrEnable);
      end
    end
    check_value("idle_corrEnable_cycles", en_seen, 0);
    check_value("idle_validOut_cycles", vcount, 0);

    // single peaks
    fill_peak(0, 14); fill_peak(1, 0);  fill_peak(2, 22);
    fill_peak(3, 11); fill_peak(4, 3);  fill_peak(5, 19);
    push_expected(14, 0, 22, 11, 3, 19);
    run_measure(1'b0, 1'b0);

    // ties, negatives, extremes, plus start/xCorrValid pokes during SCAN
    for (int k = 0; k < NK; k++) vecs[0][k] = NB'($urandom_range(0, 50));
    vecs[0][5] = 32'sd100;
    vecs[0][9] = 32'sd100;
    for (int k = 0; k < NK; k++) vecs[1][k] = -NB'($urandom_range(10, 1000));
    vecs[1][20] = -32'sd5;
    for (int k = 0; k < NK; k++) vecs[2][k] = -32'sd1;
    vecs[2][7] = 32'sh7FFFFFFF;
    for (int k = 0; k < NK; k++) vecs[3][k] = 32'sd7;
    for (int k = 0; k < NK; k++) vecs[4][k] = 32'sh80000000;
    vecs[4][12] = 32'sh80000001;
    fill_peak(5, 1);
    push_expected(5, 20, 7, 0, 12, 1);
    run_measure(1'b1, 1'b0);

    // reset in the middle of pair 3
    fill_peak(0, 2); fill_peak(1, 4); fill_peak(2, 6);
    fill_peak(3, 8); fill_peak(4, 10); fill_peak(5, 12);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < NS; i++) pulse_valid();
    cyc = 0;
    while (bus.xCorrSel != 3'd3 && cyc < 200) begin
      tick();
      cyc++;
    end
    check_value("reach_pair3", bus.xCorrSel, 3);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_value("midrst_busy", bus.busy, 0);
    check_value("midrst_validOut", bus.validOut, 0);
    check_value("midrst_xCorrSel", bus.xCorrSel, 0);
    check_lags_zero("midrst");
    vcount = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      vcount += int'(bus.validOut);
    end
    check_value("midrst_no_validOut", vcount, 0);

    // fresh full run, start held through DONE
    fill_peak(0, 22); fill_peak(1, 1);  fill_peak(2, 12);
    fill_peak(3, 6);  fill_peak(4, 21); fill_peak(5, 10);
    push_expected(22, 1, 12, 6, 21, 10);
    run_measure(1'b0, 1'b1);

    check_value("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/correlation_sequencer.md
# correlation_sequencer

Controller that sequences one direction-of-arrival measurement around the cross-correlation datapath. It gates sample updates into the correlator until a full window of `NUM_SAMPLES` new samples has been accumulated. It then freezes the correlator and scans the six cross-correlation vectors one lag per cycle. For each microphone pair it reports the lag of the maximum correlation value as a signed sample delay.

## Interface
- `NUM_SAMPLES`, 1024: samples per correlation window; must match the correlator.
- `MAX_SAMPLES_DELAY`, 11: max lag M; each vector has 2M+1 entries, index k ↔ lag k−M.
- `NUM_BITS_XCORR`, 32: width of one correlation value (signed).
- `NUM_XCORRS`, 6: number of pair vectors scanned.
- `LAG_BITS`, $clog2(MAX_SAMPLES_DELAY+1)+1: signed lag output width (5 at default).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  arm a measurement; sampled only in IDLE.
- `xCorrValid`  in  1  one-cycle pulse per sample update from the correlator.
- `xCorrIn`  in  [2M:0][NUM_BITS_XCORR-1:0] signed  vector of the pair selected by `xCorrSel`, combinational mux outside this block.
- `corrEnable`  out  1  gates the sample-valid into the correlator; registered; 1 only in FILL.
- `xCorrSel`  out  3  index of the pair currently read (0..5).
- `busy`  out  1  high in FILL, SCAN, DONE.
- `validOut`  out  1  one-cycle pulse, lag outputs updated.
- `lagOut0`..`lagOut5`  out  LAG_BITS signed  peak lag per pair, held until next DONE.

## Operation
- States: IDLE, FILL, SCAN, DONE.
- IDLE: `corrEnable`=0, `busy`=0. `start`=1 → FILL; clear sample counter.
- FILL: `corrEnable`=1. Each `xCorrValid` pulse increments the counter (width $clog2(NUM_SAMPLES+1)). The pulse that brings the count to NUM_SAMPLES → SCAN, with p=0 and k=0.
- SCAN: `xCorrSel`=p. Each cycle reads `xCorrIn[k]`.
  - At k=0: best←xCorrIn[0], bestIdx←0.
  - At k>0: update best and bestIdx only if xCorrIn[k] > best (signed, strict). Ties keep the lowest index.
  - At k=2M: lagOut[p] ← bestIdx − M, written with the final comparison included. Then k←0 and p←p+1.
  - After p=NUM_XCORRS−1, k=2M → DONE.
- DONE: `validOut`=1 for this cycle only, then → IDLE.
- `xCorrValid` pulses outside FILL are ignored. `start` outside IDLE is ignored.
- Lag arithmetic: bestIdx − M as signed LAG_BITS; range −M..+M, never saturates.
- Upstream requirement: sample-valid pulses are at least 4 clk apart, so no correlator update lands after the FILL→SCAN edge.

## Timing
- Reset values: state IDLE; `corrEnable` 0, `busy` 0, `validOut` 0, `xCorrSel` 0, all `lagOut*` 0; counters 0.
- `rst` asserted in any state, including mid-SCAN: next cycle IDLE with reset values. Partial results are discarded.
- `start` in cycle t → state FILL and `corrEnable`=1 from cycle t+1.
- NUM_SAMPLES-th `xCorrValid` in cycle t → SCAN from t+1, and `corrEnable`=0 from t+1.
- SCAN lasts exactly NUM_XCORRS·(2M+1) cycles (138 at default). `validOut` is high on the next cycle.
- `lagOut[p]` is updated on the clock edge ending the last SCAN cycle of pair p. The value is visible early, before `validOut`.
- `start` held high through DONE: IDLE for one cycle, then FILL.

## Test plan
- Reset/idle: assert `rst` 2 cycles → all outputs 0, `busy`=0. Then hold `start`=0 and send 10 `xCorrValid` pulses → `corrEnable` stays 0 and no `validOut`.
- Fill count (NUM_SAMPLES=8 build): `start`, then 7 pulses → still FILL, `corrEnable`=1. 8th pulse → `corrEnable`=0 next cycle. `validOut` exactly 138 cycles after SCAN entry (+1).
- Peak lags: per pair, drive a vector with a single peak at k=14, 0, 22, 11, 3, 19 → lagOut0..5 = +3, −11, +11, 0, −8, +8.
- Tie/negative: equal maxima at k=5 and k=9 → −6. All-negative vector with the least negative value at k=20 → +9. Peak equal to 0x7FFFFFFF vs −1 elsewhere → its index wins.
- Ignore rules: `start` and `xCorrValid` pulses during SCAN → SCAN length unchanged, no extra count, no restart.
- Reset mid-SCAN at p=3 → next cycle IDLE, lags 0, no `validOut`. A fresh run then completes normally.
